// File: rtl/phys_free_list_if.sv
// Rename/commit-facing handshake bundle of the physical-register free list.
// master = rename/commit side, slave = the free list itself.
interface phys_free_list_if #(
  parameter int PREG_WIDTH = 6
);
  logic                  alloc_req_IN;
  logic [PREG_WIDTH-1:0] alloc_tag_OUT;
  logic                  alloc_valid_OUT;
  logic                  retire_IN;
  logic                  free_IN;
  logic [PREG_WIDTH-1:0] free_tag_IN;
  logic                  flush_IN;
  logic [PREG_WIDTH:0]   avail_count_OUT;
  logic                  err_OUT;

  modport master (
    output alloc_req_IN, retire_IN, free_IN, free_tag_IN, flush_IN,
    input  alloc_tag_OUT, alloc_valid_OUT, avail_count_OUT, err_OUT
  );

  modport slave (
    input  alloc_req_IN, retire_IN, free_IN, free_tag_IN, flush_IN,
    output alloc_tag_OUT, alloc_valid_OUT, avail_count_OUT, err_OUT
  );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with a speculative and a committed head;
// a flush rolls the speculative head back to the committed one in one cycle.
module phys_free_list #(
  parameter int PREG_WIDTH = 6,
  parameter int NUM_AREGS  = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FREEZE,
  phys_free_list_if.slave   bus
);
  localparam int unsigned               DEPTH     = 1 << PREG_WIDTH;
  localparam int unsigned               INIT_FREE = DEPTH - NUM_AREGS;
  localparam logic [PREG_WIDTH:0]       FULL_CNT  = (PREG_WIDTH+1)'(DEPTH);
  localparam logic [PREG_WIDTH:0]       INIT_CNT  = (PREG_WIDTH+1)'(INIT_FREE);
  localparam logic [PREG_WIDTH-1:0]     INIT_TAIL = PREG_WIDTH'(INIT_FREE);

  logic [PREG_WIDTH-1:0] tags [DEPTH];

  logic [PREG_WIDTH-1:0] alloc_head, com_head, tail;
  logic [PREG_WIDTH:0]   spec_cnt, com_cnt;
  logic                  err;

  logic [PREG_WIDTH-1:0] alloc_head_nxt, com_head_nxt, tail_nxt;
  logic [PREG_WIDTH:0]   spec_cnt_nxt, com_cnt_nxt;
  logic                  err_nxt;
  logic                  alloc_valid, alloc_ok, retire_ok, free_ok;

  always_comb begin
    alloc_valid = (spec_cnt != '0);
    alloc_ok    = bus.alloc_req_IN && alloc_valid && !bus.flush_IN;
    retire_ok   = bus.retire_IN && (com_head != alloc_head);
    free_ok     = bus.free_IN && (com_cnt != FULL_CNT);

    com_head_nxt = com_head + PREG_WIDTH'(retire_ok);
    tail_nxt     = tail + PREG_WIDTH'(free_ok);
    com_cnt_nxt  = com_cnt + (PREG_WIDTH+1)'(free_ok) - (PREG_WIDTH+1)'(retire_ok);

    // Rollback targets the committed state as updated by this cycle's retire/free.
    if (bus.flush_IN) begin
      alloc_head_nxt = com_head_nxt;
      spec_cnt_nxt   = com_cnt_nxt;
    end else begin
      alloc_head_nxt = alloc_head + PREG_WIDTH'(alloc_ok);
      spec_cnt_nxt   = spec_cnt + (PREG_WIDTH+1)'(free_ok) - (PREG_WIDTH+1)'(alloc_ok);
    end

    err_nxt = err
            | (bus.alloc_req_IN && !alloc_valid)
            | (bus.retire_IN && (com_head == alloc_head))
            | (bus.free_IN && (com_cnt == FULL_CNT));
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tags[i] <= (i < INIT_FREE) ? PREG_WIDTH'(NUM_AREGS + i) : '0;
      end
      alloc_head <= '0;
      com_head   <= '0;
      tail       <= INIT_TAIL;
      spec_cnt   <= INIT_CNT;
      com_cnt    <= INIT_CNT;
      err        <= 1'b0;
    end else if (!FREEZE) begin
      if (free_ok) tags[tail] <= bus.free_tag_IN;
      alloc_head <= alloc_head_nxt;
      com_head   <= com_head_nxt;
      tail       <= tail_nxt;
      spec_cnt   <= spec_cnt_nxt;
      com_cnt    <= com_cnt_nxt;
      err        <= err_nxt;
    end
  end

  assign bus.alloc_tag_OUT   = tags[alloc_head];
  assign bus.alloc_valid_OUT = alloc_valid;
  assign bus.avail_count_OUT = spec_cnt;
  assign bus.err_OUT         = err;
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus random traffic against a
// queue-of-free-tags reference model.
module tb_phys_free_list;
  localparam int PW    = 6;
  localparam int NA    = 32;
  localparam int DEPTH = 1 << PW;

  logic CLK    = 1'b0;
  logic RESET  = 1'b0;
  logic FREEZE = 1'b0;

  phys_free_list_if #(.PREG_WIDTH(PW)) bus ();

  phys_free_list #(.PREG_WIDTH(PW), .NUM_AREGS(NA)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .FREEZE (FREEZE),
    .bus    (bus.slave)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: q holds free tags in hand-out order starting at the committed
  // head; outs = tags handed out speculatively but not yet retired.
  int q[$];
  int outs;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = NA; i < DEPTH; i++) q.push_back(i);
    outs  = 0;
    m_err = 1'b0;
  endfunction

  function automatic void model_step(input bit rst, input bit frz, input bit req, input bit ret,
                                     input bit fr, input int ftag, input bit fl);
    int  spec;
    bit  valid, r_ok, f_ok, a_ok;
    if (!rst) begin
      model_reset();
    end else if (!frz) begin
      spec  = q.size() - outs;
      valid = (spec != 0);
      r_ok  = ret && ((outs % DEPTH) != 0);
      f_ok  = fr && (q.size() != DEPTH);
      a_ok  = req && valid && !fl;
      if (req && !valid) m_err = 1'b1;
      if (ret && !r_ok)  m_err = 1'b1;
      if (fr && !f_ok)   m_err = 1'b1;
      if (r_ok) begin
        void'(q.pop_front());
        outs--;
      end
      if (f_ok) q.push_back(ftag % DEPTH);
      if (a_ok) outs++;
      if (fl)   outs = 0;
    end
  endfunction

  task automatic compare_all(input string ctx);
    int spec;
    spec = q.size() - outs;
    check({ctx, ".valid"}, 32'(bus.alloc_valid_OUT), 32'(spec != 0));
    check({ctx, ".count"}, 32'(bus.avail_count_OUT), spec);
    check({ctx, ".err"},   32'(bus.err_OUT), 32'(m_err));
    if (spec != 0) check({ctx, ".tag"}, 32'(bus.alloc_tag_OUT), q[outs]);
  endtask

  // Argument order: rst_n, freeze, alloc, retire, free, free_tag, flush
  task automatic cycle(input string ctx, input bit rst, input bit frz, input bit req,
                       input bit ret, input bit fr, input int ftag, input bit fl);
    RESET            = rst;
    FREEZE           = frz;
    bus.alloc_req_IN = req;
    bus.retire_IN    = ret;
    bus.free_IN      = fr;
    bus.free_tag_IN  = PW'(ftag);
    bus.flush_IN     = fl;
    @(posedge CLK);
    model_step(rst, frz, req, ret, fr, ftag, fl);
    #1;
    compare_all(ctx);
  endtask

  task automatic do_reset();
    cycle("reset", 0, 0, 0, 0, 0, 0, 0);
    cycle("reset", 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.alloc_req_IN = 1'b0;
    bus.retire_IN    = 1'b0;
    bus.free_IN      = 1'b0;
    bus.free_tag_IN  = '0;
    bus.flush_IN     = 1'b0;

    // Reset state, then drain all 32 free tags
    do_reset();
    check("rst.count", 32'(bus.avail_count_OUT), 32);
    check("rst.err",   32'(bus.err_OUT), 0);
    for (int i = 0; i < 32; i++) begin
      check("drain.seq", 32'(bus.alloc_tag_OUT), 32 + i);
      cycle("drain", 1, 0, 1, 0, 0, 0, 0);
    end
    check("drain.empty_valid", 32'(bus.alloc_valid_OUT), 0);
    check("drain.empty_count", 32'(bus.avail_count_OUT), 0);
    cycle("drain.over", 1, 0, 1, 0, 0, 0, 0);
    check("drain.over_err", 32'(bus.err_OUT), 1);

    // Alloc 4, retire 2, free 5 and 7, flush
    do_reset();
    for (int i = 0; i < 4; i++) cycle("rb.alloc", 1, 0, 1, 0, 0, 0, 0);
    cycle("rb.retire", 1, 0, 0, 1, 0, 0, 0);
    cycle("rb.retire", 1, 0, 0, 1, 0, 0, 0);
    cycle("rb.free", 1, 0, 0, 0, 1, 5, 0);
    cycle("rb.free", 1, 0, 0, 0, 1, 7, 0);
    cycle("rb.flush", 1, 0, 0, 0, 0, 0, 1);
    check("rb.count", 32'(bus.avail_count_OUT), 32);
    check("rb.head", 32'(bus.alloc_tag_OUT), 34);
    for (int i = 0; i < 30; i++) cycle("rb.realloc", 1, 0, 1, 0, 0, 0, 0);
    check("rb.after63_a", 32'(bus.alloc_tag_OUT), 5);
    cycle("rb.realloc", 1, 0, 1, 0, 0, 0, 0);
    check("rb.after63_b", 32'(bus.alloc_tag_OUT), 7);

    // Alloc + free together with one tag left
    do_reset();
    for (int i = 0; i < 31; i++) cycle("af.alloc", 1, 0, 1, 0, 0, 0, 0);
    check("af.pre_count", 32'(bus.avail_count_OUT), 1);
    cycle("af.both", 1, 0, 1, 0, 1, 9, 0);
    check("af.count", 32'(bus.avail_count_OUT), 1);
    check("af.tag", 32'(bus.alloc_tag_OUT), 9);
    cycle("af.last", 1, 0, 1, 0, 0, 0, 0);
    check("af.empty", 32'(bus.alloc_valid_OUT), 0);

    // Flush + alloc + retire in one cycle
    do_reset();
    for (int i = 0; i < 3; i++) cycle("far.alloc", 1, 0, 1, 0, 0, 0, 0);
    cycle("far.all", 1, 0, 1, 1, 0, 0, 1);
    check("far.tag", 32'(bus.alloc_tag_OUT), 33);
    check("far.count", 32'(bus.avail_count_OUT), 31);
    check("far.err", 32'(bus.err_OUT), 0);

    // Retire with nothing outstanding
    do_reset();
    cycle("bad_ret", 1, 0, 0, 1, 0, 0, 0);
    check("bad_ret.err", 32'(bus.err_OUT), 1);
    check("bad_ret.tag", 32'(bus.alloc_tag_OUT), 32);
    cycle("bad_ret.alloc", 1, 0, 1, 0, 0, 0, 0);
    cycle("bad_ret.retire", 1, 0, 0, 1, 0, 0, 0);
    cycle("bad_ret.flush", 1, 0, 0, 0, 0, 0, 1);
    check("bad_ret.count", 32'(bus.avail_count_OUT), 31);

    // Freeze holds everything
    do_reset();
    cycle("frz.alloc", 1, 0, 1, 0, 0, 0, 0);
    cycle("frz.alloc", 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("frz.hold", 1, 1, 1, 1, 1, 9, 1);
    check("frz.count", 32'(bus.avail_count_OUT), 30);
    check("frz.tag", 32'(bus.alloc_tag_OUT), 34);
    cycle("frz.resume", 1, 0, 1, 0, 0, 0, 0);
    check("frz.resume_tag", 32'(bus.alloc_tag_OUT), 35);

    // Free overflow
    do_reset();
    for (int i = 0; i < 32; i++) cycle("ovf.free", 1, 0, 0, 0, 1, i, 0);
    check("ovf.full", 32'(bus.avail_count_OUT), 64);
    check("ovf.noerr", 32'(bus.err_OUT), 0);
    cycle("ovf.over", 1, 0, 0, 0, 1, 3, 0);
    check("ovf.err", 32'(bus.err_OUT), 1);
    check("ovf.count", 32'(bus.avail_count_OUT), 64);

    // Random traffic, including mid-operation resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit rst, frz, req, ret, fr, fl;
      int ftag;
      rst  = ($urandom_range(0, 299) != 0);
      frz  = ($urandom_range(0, 9) == 0);
      req  = ($urandom_range(0, 1) == 1);
      ret  = (outs > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      fr   = (q.size() < 60) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 29) == 0);
      ftag = int'($urandom_range(0, DEPTH - 1));
      fl   = ($urandom_range(0, 24) == 0);
      cycle("rand", rst, frz, req, ret, fr, ftag, fl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
